// File: rtl/painterengine_gpu_reader.sv
`timescale 1ns/1ps
// painterengine_gpu_reader
// AXI4 burst read master that feeds the display streaming FSM with 32-bit
// pixel words. A session runs while enable is high. It fetches `length` words
// from `address` and issues INCR bursts of at most MAX_BURST beats. No burst
// crosses a BOUNDARY-byte line. R data passes straight through to the consumer
// under its data_next backpressure.
// Ports:
//   i_wire_clock / i_wire_resetn          clock, async active-low reset
//   i_wire_enable, i_wire_address/length  session control (sampled at start)
//   o_wire_done / o_wire_error            registered session status
//   o_wire_data/_data_valid, i_wire_data_next   consumer stream
//   o_wire_araddr/_arlen/_arvalid, i_wire_arready   AXI AR channel
//   i_wire_rdata/_rresp/_rlast/_rvalid, o_wire_rready AXI R channel
module painterengine_gpu_reader #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BOUNDARY  = 4096
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_enable,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_araddr,
  output logic [7:0]  o_wire_arlen,
  output logic        o_wire_arvalid,
  input  logic        i_wire_arready,
  input  logic [31:0] i_wire_rdata,
  input  logic [1:0]  i_wire_rresp,
  input  logic        i_wire_rlast,
  input  logic        i_wire_rvalid,
  output logic        o_wire_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE, S_ERROR, S_DRAIN
  } state_t;

  localparam logic [31:0] BND_BYTES = 32'(BOUNDARY);
  localparam logic [31:0] BND_MASK  = 32'(BOUNDARY - 1);

  state_t      state, state_nx;
  logic [31:0] cur_addr;
  logic [31:0] remaining;
  logic [8:0]  beat_cnt;
  logic        err_flag;
  logic        abort;
  logic [31:0] words_to_bnd;
  logic [8:0]  beats;
  logic        accept;
  logic        beat_bad;

  // Burst size: min of the words left, MAX_BURST and the words up to the boundary.
  always_comb begin
    words_to_bnd = (BND_BYTES - (cur_addr & BND_MASK)) >> 2;
    beats = 9'(MAX_BURST);
    if (remaining < 32'(beats))    beats = remaining[8:0];
    if (words_to_bnd < 32'(beats)) beats = words_to_bnd[8:0];
  end

  // A beat is bad if the slave reports an error or rlast disagrees with the count.
  assign beat_bad    = (i_wire_rresp != 2'b00) || (i_wire_rlast != (beat_cnt == 9'd1));
  assign o_wire_data = i_wire_rdata;
  assign accept      = i_wire_rvalid && o_wire_rready;

  always_comb begin
    state_nx          = state;
    o_wire_arvalid    = 1'b0;
    o_wire_rready     = 1'b0;
    o_wire_data_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_wire_enable) begin
          if (i_wire_length == '0)            state_nx = S_DONE;
          else if (i_wire_address[1:0] != '0) state_nx = S_ERROR;
          else                                state_nx = S_CALC;
        end
      end
      S_CALC: state_nx = i_wire_enable ? S_ADDR : S_IDLE;
      S_ADDR: begin
        o_wire_arvalid = 1'b1;
        if (i_wire_arready) state_nx = (abort || !i_wire_enable) ? S_DRAIN : S_DATA;
      end
      S_DATA: begin
        if (!i_wire_enable) begin
          // Abort: sink this cycle's beat ourselves so a final rlast is not missed.
          o_wire_rready = 1'b1;
          state_nx = (i_wire_rvalid && i_wire_rlast) ? S_IDLE : S_DRAIN;
        end else begin
          o_wire_rready     = i_wire_data_next;
          o_wire_data_valid = i_wire_rvalid && i_wire_data_next && (i_wire_rresp == 2'b00);
          if (accept) begin
            if (beat_bad)          state_nx = i_wire_rlast ? S_ERROR : S_DRAIN;
            else if (i_wire_rlast) state_nx = (remaining == 32'd1) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE, S_ERROR: if (!i_wire_enable) state_nx = S_IDLE;
      S_DRAIN: begin
        o_wire_rready = 1'b1;
        if (i_wire_rvalid && i_wire_rlast) state_nx = err_flag ? S_ERROR : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      err_flag      <= 1'b0;
      abort         <= 1'b0;
      o_wire_araddr <= '0;
      o_wire_arlen  <= '0;
      o_wire_done   <= 1'b0;
      o_wire_error  <= 1'b0;
    end else begin
      state        <= state_nx;
      o_wire_done  <= (state_nx == S_DONE);
      o_wire_error <= (state_nx == S_ERROR);
      case (state)
        S_IDLE: begin
          err_flag <= 1'b0;
          abort    <= 1'b0;
          if (i_wire_enable) begin
            cur_addr  <= i_wire_address;
            remaining <= i_wire_length;
          end
        end
        S_CALC: begin
          o_wire_araddr <= cur_addr;
          o_wire_arlen  <= 8'(beats - 9'd1);
          beat_cnt      <= beats;
          abort         <= 1'b0;
        end
        S_ADDR: if (!i_wire_enable) abort <= 1'b1;
        S_DATA: begin
          if (accept) begin
            beat_cnt  <= beat_cnt - 9'd1;
            remaining <= remaining - 32'd1;
            cur_addr  <= cur_addr + 32'd4;
          end
          if (i_wire_enable && state_nx == S_DRAIN) err_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
`timescale 1ns/1ps
module tb_painterengine_gpu_reader;

  logic        clk = 1'b0;
  logic        rst_n, enable, data_next;
  logic [31:0] address, length;
  logic        done, error, data_valid;
  logic [31:0] data, araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  always #5 clk = ~clk;

  painterengine_gpu_reader #(.MAX_BURST(16), .BOUNDARY(4096)) dut (
    .i_wire_clock(clk), .i_wire_resetn(rst_n), .i_wire_enable(enable),
    .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error),
    .o_wire_data(data), .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_araddr(araddr), .o_wire_arlen(arlen), .o_wire_arvalid(arvalid),
    .i_wire_arready(arready), .i_wire_rdata(rdata), .i_wire_rresp(rresp),
    .i_wire_rlast(rlast), .i_wire_rvalid(rvalid), .o_wire_rready(rready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // Scoreboard / slave state
  logic [31:0] got_q[$];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  int cyc = 0, last_dv_cyc = 0, end_cyc = 0;
  int dv_bad = 0, dv_abort = 0, rr_bad = 0;
  bit bp_mode = 0;
  bit ar_ok = 1;
  int err_burst = -1, err_beat = -1;
  int s_burst = 0, s_beats_total = 0;

  // Consumer monitor: samples pre-edge values at each rising edge.
  initial forever begin
    @(posedge clk);
    if (data_valid) begin
      got_q.push_back(data);
      last_dv_cyc = cyc;
      if (!data_next) dv_bad++;
      if (!enable) dv_abort++;
    end
    if (bp_mode && rvalid && enable && (rready !== data_next)) rr_bad++;
    cyc++;
  end

  // Consumer backpressure driver
  initial begin
    data_next = 1'b1;
    forever begin
      @(negedge clk);
      data_next = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    end
  end

  // AXI slave model: one burst at a time, rvalid continuously high while busy.
  initial begin
    bit hs_ar, hs_r;
    logic [31:0] hs_addr, s_base;
    logic [7:0]  hs_len;
    int s_nb, s_idx;
    bit s_busy;
    s_busy = 0; s_nb = 0; s_idx = 0; s_base = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    forever begin
      @(posedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      hs_addr = araddr;
      hs_len  = arlen;
      #1;
      if (!rst_n) begin
        s_busy = 0;
      end else begin
        if (hs_r) begin
          s_beats_total++;
          s_idx++;
          if (s_idx == s_nb) begin
            s_busy = 0;
            s_burst++;
          end
        end
        if (hs_ar) begin
          ar_addr_q.push_back(hs_addr);
          ar_len_q.push_back(hs_len);
          s_base = hs_addr;
          s_nb   = int'(hs_len) + 1;
          s_idx  = 0;
          s_busy = 1;
        end
      end
      arready = ar_ok && !s_busy;
      rvalid  = s_busy;
      rdata   = pat(s_base + 32'(4 * s_idx));
      rlast   = s_busy && (s_idx == s_nb - 1);
      rresp   = (s_busy && s_burst == err_burst && s_idx == err_beat) ? 2'b10 : 2'b00;
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] l);
    @(negedge clk);
    got_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
    s_burst = 0; s_beats_total = 0; dv_bad = 0; dv_abort = 0; rr_bad = 0;
    address = a; length = l; enable = 1'b1;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1;
        break;
      end
    end
    end_cyc = cyc;
    check({tag, "_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic stop_session();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [31:0] base, input int n);
    int nbad;
    nbad = 0;
    check({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      if (got_q[i] !== pat(base + 32'(4 * i))) nbad++;
    check({tag, "_words"}, 64'(nbad), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; enable = 1'b0; address = '0; length = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_dvalid", 64'(data_valid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-burst run
    start(32'h1000, 32);
    wait_end("t1", 400);
    check("t1_done", 64'(done), 64'd1);
    check("t1_error", 64'(error), 64'd0);
    check("t1_done_lat", 64'((end_cyc - last_dv_cyc) <= 2), 64'd1);
    check("t1_ar_n", 64'(ar_addr_q.size()), 64'd2);
    if (ar_addr_q.size() == 2) begin
      check("t1_ar0", 64'(ar_addr_q[0]), 64'h1000);
      check("t1_len0", 64'(ar_len_q[0]), 64'd15);
      check("t1_ar1", 64'(ar_addr_q[1]), 64'h1040);
      check("t1_len1", 64'(ar_len_q[1]), 64'd15);
    end
    check_words("t1", 32'h1000, 32);
    stop_session();
    check("t1_done_clr", 64'(done), 64'd0);

    // 4 KB boundary split
    start(32'h1FF8, 8);
    wait_end("t2", 200);
    check("t2_done", 64'(done), 64'd1);
    check("t2_ar_n", 64'(ar_addr_q.size()), 64'd2);
    if (ar_addr_q.size() == 2) begin
      check("t2_ar0", 64'(ar_addr_q[0]), 64'h1FF8);
      check("t2_len0", 64'(ar_len_q[0]), 64'd1);
      check("t2_ar1", 64'(ar_addr_q[1]), 64'h2000);
      check("t2_len1", 64'(ar_len_q[1]), 64'd5);
    end
    check_words("t2", 32'h1FF8, 8);
    stop_session();

    // Consumer backpressure
    bp_mode = 1;
    start(32'h3000, 16);
    wait_end("t3", 400);
    bp_mode = 0;
    check("t3_done", 64'(done), 64'd1);
    check("t3_rready_mirror", 64'(rr_bad), 64'd0);
    check("t3_dv_no_next", 64'(dv_bad), 64'd0);
    check_words("t3", 32'h3000, 16);
    stop_session();

    // Slave error on beat 3
    err_burst = 0; err_beat = 3;
    start(32'h4000, 16);
    wait_end("t4", 200);
    check("t4_error", 64'(error), 64'd1);
    check("t4_done", 64'(done), 64'd0);
    check("t4_drained", 64'(s_beats_total), 64'd16);
    check_words("t4", 32'h4000, 3);
    stop_session();
    check("t4_error_clr", 64'(error), 64'd0);
    err_burst = -1; err_beat = -1;

    // Abort while AR is pending
    ar_ok = 0;
    @(negedge clk);
    start(32'h5000, 16);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arvalid) begin seen = 1; break; end
    end
    check("t5_arvalid_up", 64'(seen), 64'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_arvalid_held", 64'(arvalid), 64'd1);
    ar_ok = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_burst == 1) begin seen = 1; break; end
    end
    check("t5_drain_done", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    check("t5_beats", 64'(s_beats_total), 64'd16);
    check("t5_no_dv", 64'(got_q.size()), 64'd0);
    check("t5_dv_abort", 64'(dv_abort), 64'd0);
    check("t5_idle_arvalid", 64'(arvalid), 64'd0);
    check("t5_idle_rready", 64'(rready), 64'd0);
    check("t5_idle_status", 64'({done, error}), 64'd0);
    start(32'h6000, 4);
    wait_end("t5b", 200);
    check("t5b_done", 64'(done), 64'd1);
    check("t5b_ar_n", 64'(ar_addr_q.size()), 64'd1);
    if (ar_len_q.size() == 1) check("t5b_len", 64'(ar_len_q[0]), 64'd3);
    check_words("t5b", 32'h6000, 4);
    stop_session();

    // Zero length
    start(32'h1000, 0);
    wait_end("t6", 20);
    check("t6_done", 64'(done), 64'd1);
    check("t6_error", 64'(error), 64'd0);
    check("t6_no_ar", 64'(ar_addr_q.size()), 64'd0);
    stop_session();
    check("t6_done_clr", 64'(done), 64'd0);

    // Misaligned address
    start(32'h1002, 4);
    wait_end("t7", 20);
    check("t7_error", 64'(error), 64'd1);
    check("t7_done", 64'(done), 64'd0);
    check("t7_no_ar", 64'(ar_addr_q.size()), 64'd0);
    stop_session();
    check("t7_error_clr", 64'(error), 64'd0);

    // Asynchronous reset mid-DATA
    start(32'h7000, 16);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (got_q.size() >= 3) begin seen = 1; break; end
    end
    check("t8_streaming", 64'(seen), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t8_done", 64'(done), 64'd0);
    check("t8_error", 64'(error), 64'd0);
    check("t8_arvalid", 64'(arvalid), 64'd0);
    check("t8_araddr", 64'(araddr), 64'd0);
    check("t8_arlen", 64'(arlen), 64'd0);
    check("t8_dvalid", 64'(data_valid), 64'd0);
    check("t8_rready", 64'(rready), 64'd0);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
